tt_sweep_controller: RTL and testbench



---
 rtl/tt_sweep_controller.sv | 152 +++++++++++++++
 tb/tb_tt_sweep_controller.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/tt_sweep_controller.sv
// Exhaustive truth-table sweeper: walks a small combinational DUT through every input vector,
// samples its output after a programmable dwell and scores it against an expected table.
module tt_sweep_controller #(
    parameter int unsigned             N_IN     = 3,
    parameter int unsigned             DWELL    = 4,
    parameter logic [(2**N_IN)-1:0]    EXPECTED = 8'hE8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   dut_f,
    output logic [N_IN-1:0]        vec_out,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [N_IN:0]          err_count,
    output logic                   fail_valid,
    output logic [N_IN-1:0]        first_fail_idx,
    output logic [(2**N_IN)-1:0]   captured
);

    localparam int unsigned V    = 2 ** N_IN;
    localparam int unsigned CntW = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [CntW-1:0] CntLast = CntW'(DWELL - 1);
    localparam logic [N_IN-1:0] VecLast = N_IN'(V - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [N_IN-1:0]   vec_q, vec_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [N_IN:0]     err_q, err_d;
    logic              fail_valid_q, fail_valid_d;
    logic [N_IN-1:0]   first_fail_q, first_fail_d;
    logic [V-1:0]      captured_q, captured_d;
    logic              mismatch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            vec_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_q        <= '0;
            fail_valid_q <= 1'b0;
            first_fail_q <= '0;
            captured_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            vec_q        <= vec_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_q        <= err_d;
            fail_valid_q <= fail_valid_d;
            first_fail_q <= first_fail_d;
            captured_q   <= captured_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        vec_d        = vec_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        pass_d       = pass_q;
        err_d        = err_q;
        fail_valid_d = fail_valid_q;
        first_fail_d = first_fail_q;
        captured_d   = captured_q;
        mismatch     = dut_f != EXPECTED[vec_q];

        case (state_q)
            StIdle: begin
                // abort takes priority over start
                if (start && !abort) begin
                    state_d      = StRun;
                    busy_d       = 1'b1;
                    vec_d        = '0;
                    cnt_d        = '0;
                    err_d        = '0;
                    captured_d   = '0;
                    fail_valid_d = 1'b0;
                    first_fail_d = '0;
                    pass_d       = 1'b0;
                end
            end

            StRun: begin
                if (abort) begin
                    // partial results stay visible for debug
                    state_d = StIdle;
                    busy_d  = 1'b0;
                    vec_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q != CntLast) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    captured_d[vec_q] = dut_f;
                    if (mismatch) begin
                        err_d = err_q + 1'b1;
                        if (!fail_valid_q) begin
                            fail_valid_d = 1'b1;
                            first_fail_d = vec_q;
                        end
                    end
                    cnt_d = '0;
                    if (vec_q == VecLast) begin
                        state_d = StDone;
                        busy_d  = 1'b0;
                        vec_d   = '0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                    end else begin
                        vec_d = vec_q + 1'b1;
                    end
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign vec_out        = vec_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign fail_valid     = fail_valid_q;
    assign first_fail_idx = first_fail_q;
    assign captured       = captured_q;

endmodule

// File: tb/tb_tt_sweep_controller.sv
// Self-checking bench for tt_sweep_controller: table vectors, random truth tables scored by a
// popcount model, and hand-written abort / back-to-back / async-reset sequences.
module tb_tt_sweep_controller;

    localparam int unsigned N_IN = 3;
    localparam int unsigned DWELL = 4;
    localparam int unsigned V = 8;
    localparam int unsigned L = V * DWELL;
    localparam logic [7:0] EXP = 8'hE8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       dut_f;
    logic [2:0] vec_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_count;
    logic       fail_valid;
    logic [2:0] first_fail_idx;
    logic [7:0] captured;
    logic [7:0] tt;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    // Behavioural combinational DUT: its truth table is the bench variable tt
    assign dut_f = tt[vec_out];

    tt_sweep_controller #(
        .N_IN(N_IN),
        .DWELL(DWELL),
        .EXPECTED(EXP)
    ) u_dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .abort(abort),
        .dut_f(dut_f),
        .vec_out(vec_out),
        .busy(busy),
        .done(done),
        .pass(pass),
        .err_count(err_count),
        .fail_valid(fail_valid),
        .first_fail_idx(first_fail_idx),
        .captured(captured)
    );

    typedef struct {
        logic [7:0] tt;
        int         err;
        int         first;
        bit         fv;
        bit         pas;
    } row_t;

    row_t tbl[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] all_outs();
        return {10'd0, vec_out, busy, done, pass, err_count, fail_valid, first_fail_idx, captured};
    endfunction

    // Score a whole truth table directly: mismatches are the set bits of tt ^ EXP
    task automatic model(input logic [7:0] t, output int err, output int first, output bit fv,
                         output bit pas);
        logic [7:0] diff;
        diff = t ^ EXP;
        err = 0;
        first = 0;
        fv = 1'b0;
        for (int i = 0; i < V; i++) begin
            if (diff[i]) begin
                err++;
                if (!fv) begin
                    fv = 1'b1;
                    first = i;
                end
            end
        end
        pas = (err == 0);
    endtask

    task automatic run_sweep(input logic [7:0] t, input int err, input int first, input bit fv,
                             input bit pas, input string tag);
        tt = t;
        start = 1'b1;
        tick();
        for (int k = 0; k < L; k++) begin
            check({tag, ".run"}, {busy, done, vec_out}, {1'b1, 1'b0, 3'(k / DWELL)});
            start = 1'($urandom_range(0, 1));  // stray starts while running must be ignored
            tick();
        end
        start = 1'b0;
        check({tag, ".done"}, {busy, done, vec_out}, {1'b0, 1'b1, 3'd0});
        check({tag, ".err"}, err_count, err);
        check({tag, ".fv"}, fail_valid, fv);
        if (fv) check({tag, ".first"}, first_fail_idx, first);
        check({tag, ".cap"}, captured, t);
        check({tag, ".pass"}, pass, pas);
        tick();
        check({tag, ".after"}, {busy, done, pass}, {1'b0, 1'b0, pas});
    endtask

    initial begin
        int err, first, dones;
        bit fv, pas;
        logic [7:0] rt;

        tbl[0] = '{8'hE8, 0, 0, 1'b0, 1'b1};  // majority, clean
        tbl[1] = '{8'h00, 4, 3, 1'b1, 1'b0};  // stuck at 0
        tbl[2] = '{8'h96, 6, 1, 1'b1, 1'b0};  // parity
        tbl[3] = '{8'hFF, 4, 0, 1'b1, 1'b0};  // stuck at 1, fails on vector 0
        tbl[4] = '{8'h68, 1, 7, 1'b1, 1'b0};  // only the last vector wrong

        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        tt = EXP;
        #12;
        check("reset.outs", all_outs(), 32'd0);
        rst_n = 1'b1;
        tick();
        tick();
        check("idle.outs", all_outs(), 32'd0);

        for (int i = 0; i < 5; i++) begin
            run_sweep(tbl[i].tt, tbl[i].err, tbl[i].first, tbl[i].fv, tbl[i].pas,
                      $sformatf("tbl%0d", i));
        end

        for (int i = 0; i < 6; i++) begin
            rt = 8'($urandom);
            model(rt, err, first, fv, pas);
            run_sweep(rt, err, first, fv, pas, $sformatf("rnd%0d", i));
        end

        // start held high: sweeps of L busy cycles separated by 2 idle cycles
        start = 1'b1;
        tt = EXP;
        dones = 0;
        for (int n = 0; n < 80; n++) begin
            int p;
            tick();
            p = n % (L + 2);
            check("held.busy_done", {busy, done}, {1'(p < L), 1'(p == L)});
            if (done) dones++;
        end
        check("held.dones", dones, 2);
        start = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("held.abort", {busy, done, vec_out}, 5'd0);

        // abort in cycle 10 (vector 2) with parity DUT
        tt = 8'h96;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        check("abort.vec_before", {busy, vec_out}, {1'b1, 3'd2});
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort.state", {busy, done, vec_out, pass}, 6'd0);
        check("abort.partial", {err_count, fail_valid, first_fail_idx, captured},
              {4'd1, 1'b1, 3'd1, 8'h02});
        dones = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (done || busy) dones++;
        end
        check("abort.quiet", dones, 0);
        run_sweep(EXP, 0, 0, 1'b0, 1'b1, "post_abort");
        start = 1'b1;
        abort = 1'b1;
        tick();
        check("abort_start.idle1", busy, 1'b0);
        tick();
        check("abort_start.idle2", busy, 1'b0);
        start = 1'b0;
        abort = 1'b0;

        // asynchronous reset mid-sweep at vector 5
        tt = 8'h00;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 20; k++) tick();
        check("rst.vec_before", {busy, vec_out}, {1'b1, 3'd5});
        #2 rst_n = 1'b0;
        #1;
        check("rst.async_outs", all_outs(), 32'd0);
        tick();
        #3 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rst.idle", all_outs(), 32'd0);
        end
        run_sweep(EXP, 0, 0, 1'b0, 1'b1, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
